// File: rtl/sparc_tlu_decq.sv
// -----------------------------------------------------------------------------
// sparc_tlu_decq
//
// Purpose:
//   Pending-event queue for the TLU. It is the parametrised successor to the
//   6->64 decoder. An incoming index is decoded into a registered one-hot
//   vector (dec_out). The same event is also accumulated into a sticky pending
//   bitmap (pend). Pending bits are removed by a per-index clear or by a
//   round-robin picker that hands indices to a consumer over a valid/ready
//   handshake. Typical uses are per-level trap tracking and per-vector
//   interrupt tracking.
//
// Parameters:
//   IDX_W     index width, legal range 1..8. Bitmap width N = 2**IDX_W is a
//             derived localparam and cannot be overridden.
//
// Configuration macro:
//   SPARC_TLU_DECQ_OVF_EN  when defined, ovf is a sticky flag. It is set when a
//                          set event lands on an index that is already pending
//                          and is not being cleared or picked that cycle, so
//                          the event is lost by coalescing. When the macro is
//                          undefined, ovf is tied to 0 and no overflow logic
//                          is built. The port exists in both builds.
//
// Ports:
//   rclk      in   1        clock
//   reset     in   1        synchronous, active-high reset
//   set_vld   in   1        set event this cycle
//   set_idx   in   IDX_W    index to set
//   clr_vld   in   1        clear event this cycle
//   clr_idx   in   IDX_W    index to clear
//   pick_rdy  in   1        consumer accepts the offered pick this cycle
//   dec_out   out  N        registered one-hot decode of set_idx (0 if idle)
//   pend      out  N        registered pending bitmap
//   pend_cnt  out  IDX_W+1  population count of pend
//   pick_vld  out  1        at least one bit pending
//   pick_idx  out  IDX_W    selected pending index (don't-care if !pick_vld)
//   ovf       out  1        sticky overflow flag (optional feature)
// -----------------------------------------------------------------------------
module sparc_tlu_decq #(
    parameter int IDX_W = 6
) (
    input  logic               rclk,
    input  logic               reset,
    input  logic               set_vld,
    input  logic [IDX_W-1:0]   set_idx,
    input  logic               clr_vld,
    input  logic [IDX_W-1:0]   clr_idx,
    input  logic               pick_rdy,
    output logic [(1<<IDX_W)-1:0] dec_out,
    output logic [(1<<IDX_W)-1:0] pend,
    output logic [IDX_W:0]     pend_cnt,
    output logic               pick_vld,
    output logic [IDX_W-1:0]   pick_idx,
    output logic               ovf
);

    localparam int N = 1 << IDX_W;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [N-1:0]     r_dec_out;
    logic [N-1:0]     r_pend;
    logic [IDX_W:0]   r_pend_cnt;
    logic [IDX_W-1:0] r_ptr;      // round-robin scan start position

    // -------------------------------------------------------------------------
    // Combinational signals
    // -------------------------------------------------------------------------
    logic [N-1:0]     w_s_mask;   // set mask
    logic [N-1:0]     w_c_mask;   // clear mask
    logic [N-1:0]     w_p_mask;   // consumed-pick mask
    logic [N-1:0]     w_pend_next;
    logic [IDX_W:0]   w_cnt_next;
    logic             w_pick_vld;
    logic [IDX_W-1:0] w_pick_idx;
    logic             w_pick_fire;

    // -------------------------------------------------------------------------
    // Event masks
    // -------------------------------------------------------------------------
    assign w_pick_vld  = |r_pend;
    assign w_pick_fire = w_pick_vld & pick_rdy;

    assign w_s_mask = set_vld     ? (N'(1) << set_idx)    : '0;
    assign w_c_mask = clr_vld     ? (N'(1) << clr_idx)    : '0;
    assign w_p_mask = w_pick_fire ? (N'(1) << w_pick_idx) : '0;

    // The set term is ORed in last. A same-cycle set therefore wins over a
    // clear or pick of the same index, and the set counts as a new event.
    assign w_pend_next = (r_pend & ~w_c_mask & ~w_p_mask) | w_s_mask;

    // -------------------------------------------------------------------------
    // Population count of the next bitmap. The count is registered alongside
    // pend, so it can never drift from the bitmap.
    // -------------------------------------------------------------------------
    // NOTE: every variable assigned in always_comb gets a default value before
    // any conditional assignment, so no path leaves it unassigned (no latch).
    always_comb begin
        w_cnt_next = '0;
        for (int i = 0; i < N; i++) begin
            w_cnt_next = w_cnt_next + (IDX_W+1)'(w_pend_next[i]);
        end
    end

    // -------------------------------------------------------------------------
    // Round-robin picker: the scan starts at r_ptr and wraps. Index arithmetic
    // is IDX_W bits wide and N is a power of two, so the mod-N wrap is free.
    // -------------------------------------------------------------------------
    always_comb begin
        logic             v_found;
        logic [IDX_W-1:0] v_scan;
        v_found    = 1'b0;
        v_scan     = '0;
        w_pick_idx = '0;
        for (int i = 0; i < N; i++) begin
            v_scan = r_ptr + IDX_W'(i);
            if (!v_found && r_pend[v_scan]) begin
                w_pick_idx = v_scan;
                v_found    = 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Sequential state
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments. Every register
    // then samples values from before the edge, whatever order the statements
    // are in.
    always_ff @(posedge rclk) begin
        if (reset) begin
            r_dec_out  <= '0;
            r_pend     <= '0;
            r_pend_cnt <= '0;
            r_ptr      <= '0;
        end else begin
            r_dec_out  <= w_s_mask;
            r_pend     <= w_pend_next;
            r_pend_cnt <= w_cnt_next;
            // After a handshake the next scan starts just past the consumed
            // index, so that index gets the lowest priority next time.
            if (w_pick_fire) begin
                r_ptr <= w_pick_idx + IDX_W'(1);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Optional overflow detection
    // -------------------------------------------------------------------------
`ifdef SPARC_TLU_DECQ_OVF_EN
    logic r_ovf;
    logic w_ovf_hit;

    // An event is lost only if the bit is already pending and nothing frees
    // it in the same cycle. A set that lands on a bit being cleared or picked
    // replaces the old event instead of merging with it.
    assign w_ovf_hit = set_vld & r_pend[set_idx]
                     & ~w_c_mask[set_idx] & ~w_p_mask[set_idx];

    always_ff @(posedge rclk) begin
        if (reset) begin
            r_ovf <= 1'b0;
        end else if (w_ovf_hit) begin
            r_ovf <= 1'b1;
        end
    end

    assign ovf = r_ovf;
`else
    assign ovf = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign dec_out  = r_dec_out;
    assign pend     = r_pend;
    assign pend_cnt = r_pend_cnt;
    assign pick_vld = w_pick_vld;
    assign pick_idx = w_pick_idx;

endmodule

// File: tb/tb_sparc_tlu_decq.sv
// -----------------------------------------------------------------------------
// tb_sparc_tlu_decq
//
// Purpose:
//   Directed self-checking bench for sparc_tlu_decq at IDX_W=6 (N=64).
//   Every expected value below is worked out by hand from the intended
//   behaviour.
//
// Configuration macro:
//   SPARC_TLU_DECQ_OVF_EN  selects the expected ovf value: 1 after a
//                          coalesced set when defined, 0 throughout otherwise.
// -----------------------------------------------------------------------------
module tb_sparc_tlu_decq;

    localparam int IDX_W = 6;
    localparam int N     = 1 << IDX_W;

`ifdef SPARC_TLU_DECQ_OVF_EN
    localparam logic EXP_OVF = 1'b1;
`else
    localparam logic EXP_OVF = 1'b0;
`endif

    logic             rclk;
    logic             reset;
    logic             set_vld;
    logic [IDX_W-1:0] set_idx;
    logic             clr_vld;
    logic [IDX_W-1:0] clr_idx;
    logic             pick_rdy;
    logic [N-1:0]     dec_out;
    logic [N-1:0]     pend;
    logic [IDX_W:0]   pend_cnt;
    logic             pick_vld;
    logic [IDX_W-1:0] pick_idx;
    logic             ovf;

    int checks;
    int errors;

    sparc_tlu_decq #(.IDX_W(IDX_W)) dut (
        .rclk     (rclk),
        .reset    (reset),
        .set_vld  (set_vld),
        .set_idx  (set_idx),
        .clr_vld  (clr_vld),
        .clr_idx  (clr_idx),
        .pick_rdy (pick_rdy),
        .dec_out  (dec_out),
        .pend     (pend),
        .pend_cnt (pend_cnt),
        .pick_vld (pick_vld),
        .pick_idx (pick_idx),
        .ovf      (ovf)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock. Outputs are sampled 1ns after the edge, and the next
    // inputs are driven at that point too.
    task automatic step();
        @(posedge rclk);
        #1;
    endtask

    task automatic idle();
        set_vld  = 1'b0;
        clr_vld  = 1'b0;
        pick_rdy = 1'b0;
        reset    = 1'b0;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset   = 1'b1;
        set_vld = 1'b0; set_idx = '0;
        clr_vld = 1'b0; clr_idx = '0;
        pick_rdy = 1'b0;
        step();
        step();
        idle();

        // ---- reset state
        check("rst_dec",  64'(dec_out),  64'h0);
        check("rst_pend", 64'(pend),     64'h0);
        check("rst_cnt",  64'(pend_cnt), 64'd0);
        check("rst_vld",  64'(pick_vld), 64'd0);
        check("rst_ovf",  64'(ovf),      64'd0);

        // ---- single set of 37
        set_vld = 1'b1; set_idx = 6'd37;
        step();
        set_vld = 1'b0;
        check("s37_dec",  64'(dec_out),  64'h1 << 37);
        check("s37_pend", 64'(pend),     64'h1 << 37);
        check("s37_cnt",  64'(pend_cnt), 64'd1);
        check("s37_vld",  64'(pick_vld), 64'd1);
        check("s37_idx",  64'(pick_idx), 64'd37);
        step();
        check("s37_dec0", 64'(dec_out),  64'h0);
        check("s37_hold", 64'(pend),     64'h1 << 37);
        // a clear removes it without a pick, so ptr stays at 0
        clr_vld = 1'b1; clr_idx = 6'd37;
        step();
        clr_vld = 1'b0;
        check("c37_pend", 64'(pend),     64'h0);
        check("c37_cnt",  64'(pend_cnt), 64'd0);

        // ---- set 5, 20, 63, then drain with pick_rdy held high
        set_vld = 1'b1; set_idx = 6'd5;  step();
        set_idx = 6'd20; step();
        set_idx = 6'd63; step();
        set_vld = 1'b0;
        check("drn_pend", 64'(pend),     (64'h1 << 5) | (64'h1 << 20) | (64'h1 << 63));
        check("drn_cnt",  64'(pend_cnt), 64'd3);
        check("drn_dec",  64'(dec_out),  64'h1 << 63);
        pick_rdy = 1'b1;
        check("drn_p0",   64'(pick_idx), 64'd5);
        step();
        check("drn_p1",   64'(pick_idx), 64'd20);
        check("drn_cnt1", 64'(pend_cnt), 64'd2);
        step();
        check("drn_p2",   64'(pick_idx), 64'd63);
        step();
        pick_rdy = 1'b0;
        check("drn_vld",  64'(pick_vld), 64'd0);
        check("drn_cnt0", 64'(pend_cnt), 64'd0);

        // ---- round-robin: ptr wrapped to 0, so 3 goes before 10
        set_vld = 1'b1; set_idx = 6'd3;  step();
        set_idx = 6'd10; step();
        set_vld = 1'b0;
        check("rr_first", 64'(pick_idx), 64'd3);
        // consume 3 (ptr -> 4) while setting 2 in the same cycle
        pick_rdy = 1'b1; set_vld = 1'b1; set_idx = 6'd2;
        step();
        set_vld = 1'b0;
        check("rr_pend",  64'(pend),     (64'h1 << 2) | (64'h1 << 10));
        check("rr_p10",   64'(pick_idx), 64'd10);
        step();
        check("rr_p2",    64'(pick_idx), 64'd2);
        step();                                  // ptr -> 3
        pick_rdy = 1'b0;
        check("rr_empty", 64'(pick_vld), 64'd0);

        // ---- same-cycle conflicts on index 9
        set_vld = 1'b1; set_idx = 6'd9; step();
        check("cf_cnt1",  64'(pend_cnt), 64'd1);
        clr_vld = 1'b1; clr_idx = 6'd9;          // set and clear together: set wins
        step();
        set_vld = 1'b0;
        check("cf_sc_p",  64'(pend),     64'h1 << 9);
        check("cf_sc_c",  64'(pend_cnt), 64'd1);
        check("cf_sc_o",  64'(ovf),      64'd0); // freed by C, so no loss
        check("cf_pidx",  64'(pick_idx), 64'd9);
        pick_rdy = 1'b1;                         // clear and pick together
        step();
        clr_vld = 1'b0; pick_rdy = 1'b0;         // ptr -> 10
        check("cf_cp_p",  64'(pend),     64'h0);
        check("cf_cp_c",  64'(pend_cnt), 64'd0);

        // ---- overflow: set 12 twice with no clear in between
        set_vld = 1'b1; set_idx = 6'd12; step();
        check("ov_first", 64'(ovf),      64'd0);
        step();
        set_vld = 1'b0;
        check("ov_cnt",   64'(pend_cnt), 64'd1);
        check("ov_set",   64'(ovf),      64'(EXP_OVF));
        clr_vld = 1'b1; clr_idx = 6'd12; step();
        clr_vld = 1'b0;
        check("ov_clr_p", 64'(pend),     64'h0);
        check("ov_stick", 64'(ovf),      64'(EXP_OVF));

        // ---- fill all 64 indices
        set_vld = 1'b1;
        for (int i = 0; i < N; i++) begin
            set_idx = IDX_W'(i);
            step();
        end
        set_vld = 1'b0;
        check("fill_p",   64'(pend),     64'hFFFF_FFFF_FFFF_FFFF);
        check("fill_c",   64'(pend_cnt), 64'd64);
        check("fill_idx", 64'(pick_idx), 64'd10);  // ptr is 10
        // reset with pick_rdy high: no handshake, everything cleared
        reset = 1'b1; pick_rdy = 1'b1;
        step();
        idle();
        check("rs_pend",  64'(pend),     64'h0);
        check("rs_cnt",   64'(pend_cnt), 64'd0);
        check("rs_vld",   64'(pick_vld), 64'd0);
        check("rs_ovf",   64'(ovf),      64'd0);
        // ptr must be 0: with {1,20} pending, ptr=0 picks 1, ptr=11 picks 20
        set_vld = 1'b1; set_idx = 6'd20; step();
        set_idx = 6'd1; step();
        set_vld = 1'b0;
        check("rs_ptr",   64'(pick_idx), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard time limit so the run cannot hang.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got no end expected end");
        $fatal(1, "timeout");
    end

endmodule
